port_rx_fwd_fsm: RTL and testbench

- Per-port ingress stage. It sits between the port RX FIFO and the port ring tap.
- For each packet it peeks the SOP word, issues a forwarding-table lookup on the destination MAC and waits for the result vector.
- It then presents the vector on the lfli channel, followed by the packet words on the lprx channel.
- Packets whose vector is empty after self-masking are drained and discarded locally, because the ring tap never consumes their data.

---
 rtl/port_rx_fwd_fsm_pkg.sv | 35 +++
 rtl/port_rx_out_reg.sv | 29 ++
 rtl/port_rx_fwd_fsm.sv | 132 +++++++++++++
 tb/tb_port_rx_fwd_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/port_rx_fwd_fsm_pkg.sv
// Shared definitions for the port RX forwarding stage: port count, PCC field layout,
// PCC codes, MAC field position and the FSM state encoding.
package port_rx_fwd_fsm_pkg;

    localparam int unsigned NUM_PORTS = 4;

    // PCC field sits in the top PRW_PCC bits of every port data word.
    localparam int unsigned PRW_PCC  = 3;
    localparam int unsigned PRW_DATA = 64 - PRW_PCC;

    typedef logic [PRW_PCC-1:0] pcc_t;

    // One flag per bit so a single-word packet is SOP|EOP.
    localparam int unsigned PCC_SOP_BIT = 0;
    localparam int unsigned PCC_EOP_BIT = 1;
    localparam int unsigned PCC_BAD_BIT = 2;

    localparam pcc_t PCC_DATA   = 3'b000;
    localparam pcc_t PCC_SOP    = 3'b001;
    localparam pcc_t PCC_EOP    = 3'b010;
    localparam pcc_t PCC_BADEOP = 3'b110;

    localparam int unsigned MAC_LO = 0;
    localparam int unsigned MAC_W  = 48;

    typedef enum logic [5:0] {
        s_idle = 6'b000001,
        s_req  = 6'b000010,
        s_resp = 6'b000100,
        s_fli  = 6'b001000,
        s_pass = 6'b010000,
        s_drop = 6'b100000
    } state_t;

endpackage

// File: rtl/port_rx_out_reg.sv
// One-entry srdy/drdy registered output stage; full-rate pass-through when the sink is ready.
module port_rx_out_reg #(
    parameter int unsigned width = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_data,
    input  logic             in_srdy,
    output logic             in_drdy,
    output logic [width-1:0] out_data,
    output logic             out_srdy,
    input  logic             out_drdy
);

    assign in_drdy = ~out_srdy | out_drdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_srdy <= 1'b0;
        end else if (in_srdy && in_drdy) begin
            out_data <= in_data;
            out_srdy <= 1'b1;
        end else if (out_drdy) begin
            out_srdy <= 1'b0;
        end
    end

endmodule

// File: rtl/port_rx_fwd_fsm.sv
// Per-port ingress stage: lookup on SOP dst MAC, present vector, then forward or drain the packet.
// Statistics counters are built only when PORT_RX_STATS_EN is defined.
module port_rx_fwd_fsm
    import port_rx_fwd_fsm_pkg::*;
#(
    parameter int unsigned pdp_sz  = 64,
    parameter int unsigned portnum = 0,
    parameter int unsigned cnt_sz  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [pdp_sz-1:0]    prx_data,
    input  logic                 prx_srdy,
    output logic                 prx_drdy,
    output logic [47:0]          lreq_dst,
    output logic                 lreq_srdy,
    input  logic                 lreq_drdy,
    input  logic [NUM_PORTS-1:0] lres_vec,
    input  logic                 lres_srdy,
    output logic                 lres_drdy,
    output logic [NUM_PORTS-1:0] lfli_data,
    output logic                 lfli_srdy,
    input  logic                 lfli_drdy,
    output logic [pdp_sz-1:0]    lprx_data,
    output logic                 lprx_srdy,
    input  logic                 lprx_drdy,
    output logic [cnt_sz-1:0]    stat_fwd,
    output logic [cnt_sz-1:0]    stat_drop,
    output logic [cnt_sz-1:0]    stat_bad
);

    localparam int unsigned PCC_LO = pdp_sz - PRW_PCC;
    localparam logic [NUM_PORTS-1:0] self_mask = ~(NUM_PORTS'(1) << portnum);

    state_t               state;
    logic                 rx_sop;
    logic                 rx_eop;
    logic                 rx_xfer;
    logic                 out_in_drdy;
    logic                 out_in_srdy;
    logic [NUM_PORTS-1:0] masked_vec;

    assign rx_sop     = prx_data[PCC_LO + PCC_SOP_BIT];
    assign rx_eop     = prx_data[PCC_LO + PCC_EOP_BIT];
    assign masked_vec = lres_vec & self_mask;

    assign lreq_srdy = (state == s_req);
    assign lres_drdy = (state == s_resp);
    assign lfli_srdy = (state == s_fli);

    // Idle consumes only stray words; the SOP word is peeked and held for s_pass.
    assign prx_drdy = ~reset & (((state == s_idle) & prx_srdy & ~rx_sop) |
                                ((state == s_pass) & out_in_drdy) |
                                (state == s_drop));
    assign rx_xfer     = prx_srdy & prx_drdy;
    assign out_in_srdy = (state == s_pass) & prx_srdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= s_idle;
            lreq_dst  <= '0;
            lfli_data <= '0;
        end else begin
            unique case (state)
                s_idle: begin
                    if (prx_srdy && rx_sop) begin
                        lreq_dst <= prx_data[MAC_LO +: MAC_W];
                        state    <= s_req;
                    end
                end
                s_req: begin
                    if (lreq_drdy) state <= s_resp;
                end
                s_resp: begin
                    if (lres_srdy) begin
                        lfli_data <= masked_vec;
                        state     <= (masked_vec != '0) ? s_fli : s_drop;
                    end
                end
                s_fli: begin
                    if (lfli_drdy) state <= s_pass;
                end
                s_pass, s_drop: begin
                    if (rx_xfer && rx_eop) state <= s_idle;
                end
                default: state <= s_idle;
            endcase
        end
    end

    port_rx_out_reg #(.width(pdp_sz)) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .in_data  (prx_data),
        .in_srdy  (out_in_srdy),
        .in_drdy  (out_in_drdy),
        .out_data (lprx_data),
        .out_srdy (lprx_srdy),
        .out_drdy (lprx_drdy)
    );

`ifdef PORT_RX_STATS_EN
    logic rx_bad;
    logic fwd_inc;
    logic drop_inc;
    logic bad_inc;

    assign rx_bad   = prx_data[PCC_LO + PCC_BAD_BIT];
    assign fwd_inc  = (state == s_pass) & rx_xfer & rx_eop & ~rx_bad;
    assign drop_inc = (state == s_drop) & rx_xfer & rx_eop;
    assign bad_inc  = ((state == s_pass) & rx_xfer & rx_eop & rx_bad) |
                      ((state == s_idle) & rx_xfer);

    // Saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fwd  <= '0;
            stat_drop <= '0;
            stat_bad  <= '0;
        end else begin
            if (fwd_inc  && (stat_fwd  != '1)) stat_fwd  <= stat_fwd  + cnt_sz'(1);
            if (drop_inc && (stat_drop != '1)) stat_drop <= stat_drop + cnt_sz'(1);
            if (bad_inc  && (stat_bad  != '1)) stat_bad  <= stat_bad  + cnt_sz'(1);
        end
    end
`else
    assign stat_fwd  = '0;
    assign stat_drop = '0;
    assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_port_rx_fwd_fsm.sv
// Scoreboard bench for port_rx_fwd_fsm: RX source, lookup responder and sinks run in one
// environment loop; the directed sequence pushes expectations as it drives packets.
module tb_port_rx_fwd_fsm;
    import port_rx_fwd_fsm_pkg::*;

    localparam int unsigned CW   = 2;
    localparam int          MAXC = (1 << CW) - 1;
`ifdef PORT_RX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [63:0]          prx_data;
    logic                 prx_srdy;
    logic                 prx_drdy;
    logic [47:0]          lreq_dst;
    logic                 lreq_srdy;
    logic                 lreq_drdy;
    logic [NUM_PORTS-1:0] lres_vec;
    logic                 lres_srdy;
    logic                 lres_drdy;
    logic [NUM_PORTS-1:0] lfli_data;
    logic                 lfli_srdy;
    logic                 lfli_drdy;
    logic [63:0]          lprx_data;
    logic                 lprx_srdy;
    logic                 lprx_drdy;
    logic [CW-1:0]        stat_fwd;
    logic [CW-1:0]        stat_drop;
    logic [CW-1:0]        stat_bad;

    port_rx_fwd_fsm #(.pdp_sz(64), .portnum(0), .cnt_sz(CW)) dut (
        .clk(clk), .reset(reset),
        .prx_data(prx_data), .prx_srdy(prx_srdy), .prx_drdy(prx_drdy),
        .lreq_dst(lreq_dst), .lreq_srdy(lreq_srdy), .lreq_drdy(lreq_drdy),
        .lres_vec(lres_vec), .lres_srdy(lres_srdy), .lres_drdy(lres_drdy),
        .lfli_data(lfli_data), .lfli_srdy(lfli_srdy), .lfli_drdy(lfli_drdy),
        .lprx_data(lprx_data), .lprx_srdy(lprx_srdy), .lprx_drdy(lprx_drdy),
        .stat_fwd(stat_fwd), .stat_drop(stat_drop), .stat_bad(stat_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lprx_cnt = 0;
    int m_fwd = 0, m_drop = 0, m_bad = 0;

    logic [63:0]          rx_q[$];
    logic [47:0]          exp_dst_q[$];
    logic [NUM_PORTS-1:0] exp_fli_q[$];
    logic [63:0]          exp_word_q[$];
    logic [NUM_PORTS-1:0] lut_q[$];
    logic [NUM_PORTS-1:0] pend_q[$];
    logic                 drdy_pat[$];
    int                   eop_cyc_q[$];
    int                   rise_cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic logic [63:0] mkw(input pcc_t p, input logic [47:0] d);
        return {p, 13'h0, d};
    endfunction

    task automatic chk_stats(input string tag);
        chk({tag, "_fwd"},  64'(stat_fwd),  STATS_EN ? 64'(m_fwd)  : 64'd0);
        chk({tag, "_drop"}, 64'(stat_drop), STATS_EN ? 64'(m_drop) : 64'd0);
        chk({tag, "_bad"},  64'(stat_bad),  STATS_EN ? 64'(m_bad)  : 64'd0);
    endtask

    // Queue one packet and its expected lookup, vector, words and counter effect.
    task automatic send_pkt(input logic [47:0] mac, input logic [NUM_PORTS-1:0] vec,
                            input int nwords, input pcc_t last);
        logic [NUM_PORTS-1:0] masked;
        pcc_t                 p;
        logic [63:0]          w;
        @(posedge clk); #2;
        masked = vec & 4'b1110;
        exp_dst_q.push_back(mac);
        lut_q.push_back(vec);
        if (masked != '0) exp_fli_q.push_back(masked);
        for (int i = 0; i < nwords; i++) begin
            p = (i == 0) ? PCC_SOP : PCC_DATA;
            if (i == nwords - 1) p = p | last;
            w = mkw(p, (i == 0) ? mac : {mac[23:0], 24'(i)});
            rx_q.push_back(w);
            if (masked != '0) exp_word_q.push_back(w);
        end
        if (masked == '0)           m_drop = sat(m_drop);
        else if (last == PCC_BADEOP) m_bad  = sat(m_bad);
        else                         m_fwd  = sat(m_fwd);
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (rx_q.size() == 0) && (exp_dst_q.size() == 0) && (exp_fli_q.size() == 0) &&
                   (exp_word_q.size() == 0) && (pend_q.size() == 0) && !lprx_srdy;
        end
        chk({tag, "_drain"}, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Environment: RX FIFO model, lookup responder, lfli/lprx sinks and scoreboard checks.
    initial begin
        bit          rx_fire, lres_fire, lreq_prev;
        logic [63:0] dummy;
        prx_srdy = 1'b0; prx_data = '0; lreq_drdy = 1'b1; lres_srdy = 1'b0;
        lres_vec = '0; lfli_drdy = 1'b1; lprx_drdy = 1'b1; lreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rx_fire   = prx_srdy && prx_drdy && !reset;
            lres_fire = lres_srdy && lres_drdy;
            if (rx_fire && prx_data[62]) eop_cyc_q.push_back(cyc);
            if (lreq_srdy && !lreq_prev) rise_cyc_q.push_back(cyc);
            lreq_prev = lreq_srdy;
            if (lreq_srdy && lreq_drdy) begin
                chk("lreq_dst", 64'(lreq_dst), (exp_dst_q.size() > 0) ? 64'(exp_dst_q.pop_front()) : 64'bx);
                pend_q.push_back((lut_q.size() > 0) ? lut_q.pop_front() : 4'b0);
            end
            if (lfli_srdy && lfli_drdy)
                chk("lfli_data", 64'(lfli_data), (exp_fli_q.size() > 0) ? 64'(exp_fli_q.pop_front()) : 64'bx);
            if (lprx_srdy && lprx_drdy) begin
                chk("lprx_data", lprx_data, (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 64'bx);
                lprx_cnt++;
            end
            @(posedge clk); #1;
            if (rx_fire) dummy = rx_q.pop_front();
            if (lres_fire) void'(pend_q.pop_front());
            prx_srdy  = (rx_q.size() > 0);
            prx_data  = (rx_q.size() > 0) ? rx_q[0] : '0;
            lres_srdy = (pend_q.size() > 0);
            lres_vec  = (pend_q.size() > 0) ? pend_q[0] : '0;
            lprx_drdy = (drdy_pat.size() > 0) ? drdy_pat.pop_front() : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_left;
        int c0;
        bit seen;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lreq_srdy", 64'(lreq_srdy), 64'd0);
        chk("rst_lres_drdy", 64'(lres_drdy), 64'd0);
        chk("rst_lfli_srdy", 64'(lfli_srdy), 64'd0);
        chk("rst_lprx_srdy", 64'(lprx_srdy), 64'd0);
        chk("rst_prx_drdy",  64'(prx_drdy),  64'd0);
        chk("rst_lreq_dst",  64'(lreq_dst),  64'd0);
        chk("rst_lfli_data", 64'(lfli_data), 64'd0);
        chk_stats("rst");
        @(posedge clk); #2; reset = 1'b0;

        send_pkt(48'h0000_1122_3344, 4'b0110, 4, PCC_EOP);
        drain("fwd4");
        chk_stats("fwd4");

        send_pkt(48'h0000_5566_7788, 4'b0001, 4, PCC_EOP);
        drain("self_drop");
        chk_stats("self_drop");

        @(posedge clk); #2;
        rx_q.push_back(mkw(PCC_DATA, 48'hAA));
        rx_q.push_back(mkw(PCC_DATA, 48'hBB));
        m_bad = sat(m_bad); m_bad = sat(m_bad);
        send_pkt(48'h0000_0A0B_0C0D, 4'b1000, 2, PCC_EOP);
        drain("stray");
        chk_stats("stray");

        send_pkt(48'h0000_DEAD_BEEF, 4'b0101, 3, PCC_BADEOP);
        drain("badeop");
        chk_stats("badeop");

        send_pkt(48'h0000_0000_0042, 4'b0011, 1, PCC_EOP);
        drain("single");
        chk_stats("single");

        c0 = lprx_cnt;
        send_pkt(48'h0000_CAFE_0001, 4'b1111, 8, PCC_EOP);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (lprx_cnt != c0);
        end
        chk("toggle_start", 64'(seen), 64'd1);
        @(posedge clk); #2;
        drdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        drain("toggle");
        chk_stats("toggle");

        eop_cyc_q.delete();
        rise_cyc_q.delete();
        send_pkt(48'h0000_0B2B_0001, 4'b0100, 3, PCC_EOP);
        send_pkt(48'h0000_0B2B_0002, 4'b1010, 3, PCC_EOP);
        drain("b2b");
        chk_stats("b2b");
        chk("b2b_rises", 64'(rise_cyc_q.size()), 64'd2);
        chk("b2b_gap", 64'((rise_cyc_q.size() > 1 && eop_cyc_q.size() > 0) ?
                           rise_cyc_q[1] - eop_cyc_q[0] : -1), 64'd2);

        c0 = lprx_cnt;
        send_pkt(48'h0000_0123_4567, 4'b0010, 8, PCC_EOP);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (lprx_cnt >= c0 + 2);
        end
        chk("rstmid_start", 64'(seen), 64'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rstmid_lprx_srdy", 64'(lprx_srdy), 64'd0);
        chk("rstmid_lreq_srdy", 64'(lreq_srdy), 64'd0);
        chk("rstmid_lfli_srdy", 64'(lfli_srdy), 64'd0);
        chk("rstmid_prx_drdy",  64'(prx_drdy),  64'd0);
        n_left = rx_q.size();
        exp_word_q.delete();
        m_fwd = 0; m_drop = 0; m_bad = 0;
        chk_stats("rstmid");
        for (int i = 0; i < n_left; i++) m_bad = sat(m_bad);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        drain("rstmid_stray");
        chk_stats("rstmid_stray");

        send_pkt(48'h0000_7654_3210, 4'b1100, 3, PCC_EOP);
        drain("post_rst");
        chk_stats("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
